// File: rtl/irq_controller.sv
// External interrupt controller: synchronises sources, latches them as pending and
// presents the lowest-numbered enabled one to the core on meip_o until claimed.
module irq_controller #(
    parameter int          NUM_SRC   = 8,
    parameter logic [10:0] BASE_ADDR = 11'h700
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [NUM_SRC-1:0] irq_src_i,
    input  logic               irq_ack_i,
    output logic               meip_o,
    input  logic [10:0]        addr_i,
    input  logic               wen_i,
    input  logic [3:0]         wmask_i,
    input  logic [31:0]        data_i,
    output logic [31:0]        data_o
);
    typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_IN_SERVICE} state_e;

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] sync1_q, sync2_q, prev_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] trigger_q, trigger_d;
    logic [4:0]         claim_q, claim_d;
    logic [31:0]        data_q, data_d;

    logic               in_win, wr_ok, wr_pend, wr_en, wr_trig, wr_claim;
    logic [NUM_SRC-1:0] act, edge_set, clr, sel_oh;
    logic               sel_vld, ack_take;
    logic [4:0]         sel_id;
    logic               unused_data;

    assign unused_data = ^data_i;

    // Window decode: 16-byte aligned, only full-word aligned writes land.
    assign in_win   = (addr_i[10:4] == BASE_ADDR[10:4]);
    assign wr_ok    = !wen_i && in_win && (addr_i[1:0] == 2'b00) && (wmask_i == 4'b1111);
    assign wr_pend  = wr_ok && (addr_i[3:2] == 2'd0);
    assign wr_en    = wr_ok && (addr_i[3:2] == 2'd1);
    assign wr_trig  = wr_ok && (addr_i[3:2] == 2'd2);
    assign wr_claim = wr_ok && (addr_i[3:2] == 2'd3);

    assign act      = pending_q & enable_q;
    assign edge_set = sync2_q & ~prev_q;

    always_comb begin
        sel_vld = 1'b0;
        sel_id  = '0;
        sel_oh  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (act[i]) begin
                sel_vld   = 1'b1;
                sel_id    = 5'(i + 1);
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
            end
        end
    end

    assign ack_take = (state_q == S_ASSERT) && irq_ack_i && sel_vld;
    assign clr      = (wr_pend ? data_i[NUM_SRC-1:0] : '0) | (ack_take ? sel_oh : '0);

    // Edge sources: set beats clear. Level sources simply follow the synchronised line.
    assign pending_d = (trigger_q & ((pending_q & ~clr) | edge_set)) | (~trigger_q & sync2_q);
    assign enable_d  = wr_en   ? data_i[NUM_SRC-1:0] : enable_q;
    assign trigger_d = wr_trig ? data_i[NUM_SRC-1:0] : trigger_q;

    always_comb begin
        state_d = state_q;
        claim_d = claim_q;
        case (state_q)
            S_IDLE: if (|act) state_d = S_ASSERT;
            S_ASSERT: begin
                if (!sel_vld) begin
                    state_d = S_IDLE;
                end else if (irq_ack_i) begin
                    claim_d = sel_id;
                    state_d = S_IN_SERVICE;
                end
            end
            S_IN_SERVICE: begin
                if (wr_claim && (data_i[4:0] == claim_q)) begin
                    claim_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        data_d = '0;
        if (in_win) begin
            case (addr_i[3:2])
                2'd0:    data_d = 32'(pending_q);
                2'd1:    data_d = 32'(enable_q);
                2'd2:    data_d = 32'(trigger_q);
                default: data_d = 32'(claim_q);
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= S_IDLE;
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            pending_q <= '0;
            enable_q  <= '0;
            trigger_q <= '0;
            claim_q   <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= irq_src_i;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            trigger_q <= trigger_d;
            claim_q   <= claim_d;
            data_q    <= data_d;
        end
    end

    assign meip_o = (state_q == S_ASSERT);
    assign data_o = data_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: inputs driven and outputs sampled on the falling edge.
module tb_irq_controller;
    localparam int NSRC = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NSRC-1:0] irq_src = '0;
    logic            irq_ack = 1'b0;
    logic            meip;
    logic [10:0]     addr = 11'h700;
    logic            wen = 1'b1;
    logic [3:0]      wmask = 4'hF;
    logic [31:0]     wdata = '0;
    logic [31:0]     data_o;
    logic [31:0]     rd;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    irq_controller #(.NUM_SRC(NSRC), .BASE_ADDR(11'h700)) dut (
        .clk_i(clk), .reset_i(rst_n), .irq_src_i(irq_src), .irq_ack_i(irq_ack),
        .meip_o(meip), .addr_i(addr), .wen_i(wen), .wmask_i(wmask),
        .data_i(wdata), .data_o(data_o)
    );

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [10:0] a, input logic [31:0] d, input logic [3:0] m);
        addr = a; wdata = d; wmask = m; wen = 1'b0;
        @(posedge clk); @(negedge clk);
        wen = 1'b1; wmask = 4'hF;
    endtask

    task automatic bus_read(input logic [10:0] a, output logic [31:0] d);
        addr = a;
        @(posedge clk); @(negedge clk);
        d = data_o;
    endtask

    task automatic ack_pulse();
        irq_ack = 1'b1;
        cycles(1);
        irq_ack = 1'b0;
    endtask

    task automatic test_reset();
        cycles(3);
        n_cmp++; if (meip !== 1'b0) begin n_err++; $display("FAIL rst_meip: got %0h want 0", meip); end
        n_cmp++; if (data_o !== 32'h0) begin n_err++; $display("FAIL rst_data: got %0h want 0", data_o); end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus_read(11'h700 + 11'(4 * k), rd);
            n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL rst_read_%0d: got %0h want 0", k, rd); end
        end
    endtask

    task automatic test_edge_basic();
        bus_write(11'h704, 32'h1, 4'hF);
        bus_write(11'h708, 32'h1, 4'hF);
        irq_src = 8'h01;
        cycles(1);
        irq_src = 8'h00;
        cycles(2);
        n_cmp++; if (meip !== 1'b0) begin n_err++; $display("FAIL edge_meip_c3: got %0h want 0", meip); end
        addr = 11'h700;
        cycles(1);
        n_cmp++; if (meip !== 1'b1) begin n_err++; $display("FAIL edge_meip_c4: got %0h want 1", meip); end
        n_cmp++; if (data_o !== 32'h1) begin n_err++; $display("FAIL edge_pending: got %0h want 1", data_o); end
        ack_pulse();
        n_cmp++; if (meip !== 1'b0) begin n_err++; $display("FAIL edge_meip_ack: got %0h want 0", meip); end
        bus_read(11'h70C, rd);
        n_cmp++; if (rd !== 32'h1) begin n_err++; $display("FAIL edge_claim: got %0h want 1", rd); end
        bus_read(11'h700, rd);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL edge_pend_clr: got %0h want 0", rd); end
        bus_write(11'h70C, 32'h1, 4'hF);
        ack_pulse();
        bus_read(11'h70C, rd);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL edge_done_claim: got %0h want 0", rd); end
        n_cmp++; if (meip !== 1'b0) begin n_err++; $display("FAIL edge_done_meip: got %0h want 0", meip); end
    endtask

    task automatic test_priority_claim();
        bus_write(11'h704, 32'h0C, 4'hF);
        bus_write(11'h708, 32'h0C, 4'hF);
        irq_src = 8'h0C;
        cycles(4);
        n_cmp++; if (meip !== 1'b1) begin n_err++; $display("FAIL pri_meip: got %0h want 1", meip); end
        ack_pulse();
        bus_read(11'h70C, rd);
        n_cmp++; if (rd !== 32'h3) begin n_err++; $display("FAIL pri_claim3: got %0h want 3", rd); end
        bus_read(11'h700, rd);
        n_cmp++; if (rd !== 32'h8) begin n_err++; $display("FAIL pri_pend: got %0h want 8", rd); end
        bus_write(11'h70C, 32'h4, 4'hF);
        cycles(1);
        n_cmp++; if (meip !== 1'b0) begin n_err++; $display("FAIL pri_bad_claim_meip: got %0h want 0", meip); end
        bus_read(11'h70C, rd);
        n_cmp++; if (rd !== 32'h3) begin n_err++; $display("FAIL pri_bad_claim_id: got %0h want 3", rd); end
        bus_write(11'h70C, 32'h3, 4'hF);
        n_cmp++; if (meip !== 1'b0) begin n_err++; $display("FAIL pri_idle_gap: got %0h want 0", meip); end
        cycles(1);
        n_cmp++; if (meip !== 1'b1) begin n_err++; $display("FAIL pri_reassert: got %0h want 1", meip); end
        ack_pulse();
        bus_read(11'h70C, rd);
        n_cmp++; if (rd !== 32'h4) begin n_err++; $display("FAIL pri_claim4: got %0h want 4", rd); end
        bus_write(11'h70C, 32'h4, 4'hF);
        irq_src = 8'h00;
        cycles(1);
        n_cmp++; if (meip !== 1'b0) begin n_err++; $display("FAIL pri_drained: got %0h want 0", meip); end
    endtask

    task automatic test_level();
        bus_write(11'h708, 32'h00, 4'hF);
        bus_write(11'h704, 32'h20, 4'hF);
        irq_src = 8'h20;
        cycles(4);
        n_cmp++; if (meip !== 1'b1) begin n_err++; $display("FAIL lvl_meip: got %0h want 1", meip); end
        ack_pulse();
        bus_read(11'h70C, rd);
        n_cmp++; if (rd !== 32'h6) begin n_err++; $display("FAIL lvl_claim: got %0h want 6", rd); end
        bus_read(11'h700, rd);
        n_cmp++; if (rd !== 32'h20) begin n_err++; $display("FAIL lvl_pend: got %0h want 20", rd); end
        bus_write(11'h70C, 32'h6, 4'hF);
        cycles(1);
        n_cmp++; if (meip !== 1'b1) begin n_err++; $display("FAIL lvl_reassert: got %0h want 1", meip); end
        irq_src = 8'h00;
        cycles(2);
        n_cmp++; if (meip !== 1'b1) begin n_err++; $display("FAIL lvl_hold: got %0h want 1", meip); end
        cycles(2);
        n_cmp++; if (meip !== 1'b0) begin n_err++; $display("FAIL lvl_drop: got %0h want 0", meip); end
    endtask

    task automatic test_w1c_race();
        bus_write(11'h704, 32'h00, 4'hF);
        bus_write(11'h708, 32'h02, 4'hF);
        irq_src = 8'h02;
        cycles(4);
        irq_src = 8'h00;
        cycles(4);
        bus_read(11'h700, rd);
        n_cmp++; if (rd !== 32'h2) begin n_err++; $display("FAIL w1c_pend: got %0h want 2", rd); end
        n_cmp++; if (meip !== 1'b0) begin n_err++; $display("FAIL w1c_disabled_meip: got %0h want 0", meip); end
        irq_src = 8'h02;
        cycles(2);
        bus_write(11'h700, 32'h2, 4'hF);
        bus_read(11'h700, rd);
        n_cmp++; if (rd !== 32'h2) begin n_err++; $display("FAIL w1c_set_wins: got %0h want 2", rd); end
        bus_write(11'h700, 32'h2, 4'hF);
        bus_read(11'h700, rd);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL w1c_clear: got %0h want 0", rd); end
        irq_src = 8'h00;
        cycles(4);
    endtask

    task automatic test_bad_writes_and_reset();
        bus_write(11'h704, 32'hFF, 4'b0011);
        bus_read(11'h704, rd);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL bad_mask: got %0h want 0", rd); end
        bus_write(11'h705, 32'hFF, 4'hF);
        bus_read(11'h704, rd);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL bad_align: got %0h want 0", rd); end
        bus_write(11'h604, 32'hFF, 4'hF);
        bus_read(11'h704, rd);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL bad_window: got %0h want 0", rd); end
        bus_write(11'h704, 32'hFFFF_FF81, 4'hF);
        bus_read(11'h704, rd);
        n_cmp++; if (rd !== 32'h81) begin n_err++; $display("FAIL en_high_bits: got %0h want 81", rd); end
        bus_read(11'h604, rd);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL read_outside: got %0h want 0", rd); end
        bus_write(11'h708, 32'h01, 4'hF);
        irq_src = 8'h01;
        cycles(1);
        irq_src = 8'h00;
        cycles(3);
        n_cmp++; if (meip !== 1'b1) begin n_err++; $display("FAIL rs_meip: got %0h want 1", meip); end
        ack_pulse();
        bus_read(11'h70C, rd);
        n_cmp++; if (rd !== 32'h1) begin n_err++; $display("FAIL rs_claim: got %0h want 1", rd); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (meip !== 1'b0) begin n_err++; $display("FAIL rs_meip_now: got %0h want 0", meip); end
        n_cmp++; if (data_o !== 32'h0) begin n_err++; $display("FAIL rs_data_now: got %0h want 0", data_o); end
        cycles(2);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus_read(11'h700 + 11'(4 * k), rd);
            n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL rs_read_%0d: got %0h want 0", k, rd); end
        end
        n_cmp++; if (meip !== 1'b0) begin n_err++; $display("FAIL rs_meip_after: got %0h want 0", meip); end
    endtask

    initial begin
        test_reset();
        test_edge_basic();
        test_priority_claim();
        test_level();
        test_w1c_race();
        test_bad_writes_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Memory-mapped external interrupt controller in front of the core's machine external interrupt input.
- Collects up to NUM_SRC asynchronous sources, latches them as pending, and picks the lowest-numbered enabled pending source.
- Drives meip_o until the core acknowledges, then holds that source in service until software writes CLAIM with the matching ID.
- Sits on the core's data bus next to data memory: 11-bit byte address, active-low write enable, read data registered.

Parameters:
- NUM_SRC, 8, number of interrupt sources (1..31).
- BASE_ADDR, 11'h700, byte base of the 16-byte register window (16-byte aligned).

Ports:
- clk_i  input  1  clock; all state on posedge.
- reset_i  input  1  asynchronous active-low reset.
- irq_src_i  input  NUM_SRC  asynchronous interrupt request lines.
- irq_ack_i  input  1  one-cycle acknowledge pulse from the core (its irq_ack_o).
- meip_o  output  1  machine external interrupt request to the core.
- addr_i  input  11  data bus byte address.
- wen_i  input  1  write enable, active-low.
- wmask_i  input  4  byte write mask.
- data_i  input  32  write data.
- data_o  output  32  registered read data.

Behaviour:
- Reset (asynchronous, reset_i low) clears everything immediately:
  - meip_o=0, data_o=0.
  - PENDING, ENABLE, TRIGGER, claim_id and the synchroniser/edge flops = 0.
  - FSM goes to IDLE.
  - Asserting reset mid-service aborts service; no state survives.
- Input path: 2-flop synchroniser per source, then a previous-value flop for rising-edge detect.
- Pending update, per source i, each cycle:
  - Edge mode (TRIGGER[i]=1): set on a synchronised rising edge; cleared by a W1C write or by claim.
  - Level mode (TRIGGER[i]=0): PENDING[i] = synchronised level, registered; W1C and claim have no effect.
  - Set and clear in the same cycle: set wins.
- Register map (offset from BASE_ADDR, word access only):
  - 0x0 PENDING: read; W1C for edge sources.
  - 0x4 ENABLE: RW.
  - 0x8 TRIGGER: RW, 1=edge, 0=level.
  - 0xC CLAIM: read returns claim_id; a write is a completion.
  - Bits at or above NUM_SRC read as 0 and ignore writes.
- Bus rules:
  - A write takes effect at the posedge where wen_i=0, addr_i is in the window, addr_i[1:0]=0 and wmask_i=4'b1111. Any other write is ignored.
  - Read: data_o is loaded at every posedge with the register addressed by addr_i, or 0 if addr_i is outside the window. Data is valid the cycle after the address is presented, matching synchronous memory latency.
- Selection: sel = lowest i with PENDING[i] & ENABLE[i]. ID = i+1; ID 0 means none.
- FSM:
  - IDLE: meip_o=0. If any enabled source is pending, go to ASSERT next cycle.
  - ASSERT: meip_o=1.
    - If no enabled pending source remains (disabled or W1C), go to IDLE and deassert on the next cycle.
    - On irq_ack_i=1: latch claim_id = current sel ID, clear that edge pending bit, go to IN_SERVICE.
  - IN_SERVICE: meip_o=0.
    - A CLAIM write with data_i[4:0]==claim_id sets claim_id=0 and goes to IDLE.
    - A mismatched ID is ignored.
    - Other sources keep accumulating as pending; there is no nesting.
- irq_ack_i outside ASSERT is ignored.
- Latency:
  - Input rise at cycle 0 gives PENDING set at end of cycle 3 (visible in PENDING reads from cycle 4).
  - meip_o=1 from cycle 4, if enabled.
  - After completion, an already-pending source re-asserts meip_o two cycles after the completing write edge (one IDLE cycle).
- Level source still high after completion: re-enters ASSERT.

Test Plan:
- Reset, then read all four offsets -> data_o=0 each, one cycle after the address; meip_o=0.
- ENABLE=0x01, TRIGGER=0x01, pulse irq_src_i[0] for 1 cycle -> PENDING=0x1; meip_o=1 in cycle 4; ack -> meip_o=0, CLAIM reads 1, PENDING=0.
- ENABLE=0x0C, TRIGGER=0x0C, raise src2 and src3 together, ack -> CLAIM=3 (src2); write CLAIM=4 -> ignored, FSM stays IN_SERVICE; write CLAIM=3 -> meip_o=1 two cycles later; ack -> CLAIM=4.
- Level source src5 (TRIGGER=0, ENABLE=0x20) held high: ack, complete with 6 -> meip_o re-asserts; drop src5 while in ASSERT -> meip_o falls 3–4 cycles later with no ack.
- Edge src1 pending with ENABLE=0: W1C write 0x2 to PENDING in the same cycle a new synchronised edge arrives -> PENDING[1] stays 1.
- Write with wmask_i=4'b0011 to ENABLE, or to address BASE_ADDR+1 -> ENABLE unchanged; assert reset_i low during IN_SERVICE -> meip_o=0 and all registers 0 immediately.
